// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// Scoreboard entry layout, forwarding select encoding and controller FSM states.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = REG_W'(31);

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } hc_state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rm;
    logic             usesRn;
    logic             usesRm;
    logic             regWrite;
    logic             memRead;
  } sb_entry_t;

  // True when the entry will write a real (non-XZR) register matching idx.
  function automatic logic producesFor(input sb_entry_t ent, input logic [REG_W-1:0] idx);
    return ent.valid & ent.regWrite & (ent.rd == idx) & (ent.rd != ZERO_REG);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Forwarding source select for one EX operand: youngest producer (MEM) wins over WB.
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic             usesSrc,
  input  logic [REG_W-1:0] srcIdx,
  input  sb_entry_t        memEnt,
  input  sb_entry_t        wbEnt,
  output fwd_sel_e         sel
);

  always_comb begin
    sel = FWD_REG;
    if (usesSrc && producesFor(memEnt, srcIdx)) begin
      sel = FWD_EXMEM;
    end else if (usesSrc && producesFor(wbEnt, srcIdx)) begin
      sel = FWD_MEMWB;
    end
  end

  // Source-side fields of the older entries play no part in forwarding.
  logic unusedFields;
  assign unusedFields = ^{memEnt.rn, memEnt.rm, memEnt.usesRn, memEnt.usesRm, memEnt.memRead,
                          wbEnt.rn, wbEnt.rm, wbEnt.usesRn, wbEnt.usesRm, wbEnt.memRead};

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: EX/MEM/WB scoreboard, load-use stall, forwarding, branch flush, drain FSM.
// Optional HAZARD_CTRL_PERF_EN adds stall_cnt/flush_cnt performance counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rd,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             br_taken_ex,
  input  logic             drain_req,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             drain_done,
  output logic [1:0]       dbgState
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  // Handshake: there is no valid/ready pair here; stall/bubble/flush are same-cycle
  // combinational responses to the ID inputs and the registered scoreboard.

  sb_entry_t exEnt, memEnt, wbEnt;
  sb_entry_t idEnt;
  hc_state_e state, stateNext;
  fwd_sel_e  fwdSelA, fwdSelB;

  logic loadUse;
  logic stallRaw, bubbleRaw;
  logic allEmpty;

  always_comb begin
    idEnt          = '0;
    idEnt.valid    = 1'b1;
    idEnt.rd       = id_rd;
    idEnt.rn       = id_rn;
    idEnt.rm       = id_rm;
    idEnt.usesRn   = id_uses_rn;
    idEnt.usesRm   = id_uses_rm;
    idEnt.regWrite = id_RegWrite;
    idEnt.memRead  = id_MemRead;
  end

  assign loadUse = id_valid & exEnt.valid & exEnt.memRead & (exEnt.rd != ZERO_REG) &
                   ((id_uses_rn & (id_rn == exEnt.rd)) | (id_uses_rm & (id_rm == exEnt.rd)));

  assign allEmpty = ~(exEnt.valid | memEnt.valid | wbEnt.valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext  = state;
    stallRaw   = 1'b0;
    bubbleRaw  = 1'b0;
    drain_done = 1'b0;
    unique case (state)
      RUN: begin
        stallRaw  = loadUse;
        bubbleRaw = loadUse;
        if (drain_req) stateNext = DRAIN;
      end
      DRAIN: begin
        stallRaw  = 1'b1;
        bubbleRaw = 1'b1;
        if (!drain_req)    stateNext = RUN;
        else if (allEmpty) stateNext = HALTED;
      end
      HALTED: begin
        stallRaw   = 1'b1;
        bubbleRaw  = 1'b1;
        drain_done = 1'b1;
        if (!drain_req) stateNext = RUN;
      end
      default: stateNext = RUN;
    endcase
  end

  // A taken branch wins over any stall: the wrong-path ID instruction is discarded anyway.
  assign flush    = br_taken_ex & reset;
  assign stall    = stallRaw & ~flush;
  assign bubble   = bubbleRaw | flush;
  assign dbgState = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exEnt  <= '0;
      memEnt <= '0;
      wbEnt  <= '0;
    end else begin
      wbEnt  <= memEnt;
      memEnt <= exEnt;
      exEnt  <= (id_valid && !bubble && !flush) ? idEnt : '0;
    end
  end

  fwd_select u_fwd_a (
    .usesSrc (exEnt.usesRn),
    .srcIdx  (exEnt.rn),
    .memEnt  (memEnt),
    .wbEnt   (wbEnt),
    .sel     (fwdSelA)
  );

  fwd_select u_fwd_b (
    .usesSrc (exEnt.usesRm),
    .srcIdx  (exEnt.rm),
    .memEnt  (memEnt),
    .wbEnt   (wbEnt),
    .sel     (fwdSelB)
  );

  assign fwd_a = fwdSelA;
  assign fwd_b = fwdSelB;

`ifdef HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !flush) stall_cnt <= stall_cnt + 32'd1;
      if (flush)           flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: driver pushes expected outputs, negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam int W = 10;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rd, id_rn, id_rm;
  logic       id_uses_rn, id_uses_rm, id_RegWrite, id_MemRead;
  logic       br_taken_ex, drain_req;
  logic       stall, bubble, flush, drain_done;
  logic [1:0] fwd_a, fwd_b, dbgState;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  int unsigned exp_stall_cnt = 0;
  int unsigned exp_flush_cnt = 0;
`endif

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           fails  = 0;

  hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rd       (id_rd),
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_uses_rn  (id_uses_rn),
    .id_uses_rm  (id_uses_rm),
    .id_RegWrite (id_RegWrite),
    .id_MemRead  (id_MemRead),
    .br_taken_ex (br_taken_ex),
    .drain_req   (drain_req),
    .stall       (stall),
    .bubble      (bubble),
    .flush       (flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .drain_done  (drain_done),
    .dbgState    (dbgState)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic un, input logic um,
                        input logic rw, input logic mr);
    id_valid    = v;
    id_rd       = rd;
    id_rn       = rn;
    id_rm       = rm;
    id_uses_rn  = un;
    id_uses_rm  = um;
    id_RegWrite = rw;
    id_MemRead  = mr;
  endtask

  task automatic id_none();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // expected vector: {stall, bubble, flush, fwd_a, fwd_b, drain_done, state}
  task automatic push_exp(input string nm, input logic s, input logic b, input logic f,
                          input logic [1:0] fa, input logic [1:0] fb, input logic d,
                          input logic [1:0] st);
    exp_q.push_back({s, b, f, fa, fb, d, st});
    name_q.push_back(nm);
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    string        nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {stall, bubble, flush, fwd_a, fwd_b, drain_done, dbgState};
        checks++;
        if (act !== e) begin
          fails++;
          $display("FAIL %s: got {s,b,f,fa,fb,done,st}=%b required %b", nm, act, e);
        end
`ifdef HAZARD_CTRL_PERF_EN
        if (nm == "async_reset") begin
          exp_stall_cnt = 0;
          exp_flush_cnt = 0;
        end
        if (e[9] && !e[7]) exp_stall_cnt++;
        if (e[7])          exp_flush_cnt++;
`endif
      end
    end
  end

  // directed stimulus
  initial begin
    reset = 1'b0;
    br_taken_ex = 1'b0;
    drain_req   = 1'b0;
    id_none();

    tick(); push_exp("reset_state", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); reset = 1'b1; push_exp("idle", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);

    // load-use: LDR X3 then ADD X7 = X3 + X4
    tick(); set_id(1, 5'd3, 5'd1, 5'd2, 1, 0, 1, 1);
    push_exp("lu_issue", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); set_id(1, 5'd7, 5'd3, 5'd4, 1, 1, 1, 0);
    push_exp("lu_stall", 1, 1, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); push_exp("lu_one_cycle", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); id_none();
    push_exp("lu_fwd_wb", 0, 0, 0, 2'b10, 2'b00, 0, 2'd0);

    // ALU back-to-back on X5
    tick(); set_id(1, 5'd5, 5'd1, 5'd2, 1, 1, 1, 0);
    push_exp("alu_a", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); set_id(1, 5'd5, 5'd8, 5'd9, 1, 1, 1, 0);
    push_exp("alu_b", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); set_id(1, 5'd6, 5'd5, 5'd10, 1, 1, 1, 0);
    push_exp("alu_nomatch", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); set_id(1, 5'd11, 5'd5, 5'd5, 1, 1, 1, 0);
    push_exp("alu_mem_prio", 0, 0, 0, 2'b01, 2'b00, 0, 2'd0);
    tick(); id_none();
    push_exp("alu_wb_only", 0, 0, 0, 2'b10, 2'b10, 0, 2'd0);
    tick(); push_exp("alu_flush1", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); push_exp("alu_flush2", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);

    // XZR never stalls or forwards
    tick(); set_id(1, 5'd31, 5'd1, 5'd0, 1, 0, 1, 1);
    push_exp("xzr_issue", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); set_id(1, 5'd4, 5'd31, 5'd31, 1, 1, 1, 0);
    push_exp("xzr_nostall", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); id_none();
    push_exp("xzr_nofwd", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); push_exp("xzr_wb", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); push_exp("xzr_empty", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);

    // taken branch coinciding with a load-use match on rm
    tick(); set_id(1, 5'd9, 5'd1, 5'd0, 1, 0, 1, 1);
    push_exp("br_ld_issue", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); set_id(1, 5'd2, 5'd3, 5'd9, 1, 1, 1, 0); br_taken_ex = 1'b1;
    push_exp("br_over_stall", 0, 1, 1, 2'b00, 2'b00, 0, 2'd0);
    tick(); br_taken_ex = 1'b0;
    push_exp("br_ex_invalid", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); id_none();
    push_exp("br_fwd_b_wb", 0, 0, 0, 2'b00, 2'b10, 0, 2'd0);
    tick(); push_exp("br_tail1", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); push_exp("br_tail2", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);

    // fill three entries, then drain
    tick(); set_id(1, 5'd8, 5'd1, 5'd2, 1, 1, 1, 0);
    push_exp("fill1", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); set_id(1, 5'd9, 5'd1, 5'd8, 1, 1, 1, 0);
    push_exp("fill2", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); set_id(1, 5'd10, 5'd8, 5'd9, 1, 1, 1, 0);
    push_exp("fwd_b_mem", 0, 0, 0, 2'b00, 2'b01, 0, 2'd0);
    tick(); id_none(); drain_req = 1'b1;
    push_exp("drain_req_run", 0, 0, 0, 2'b10, 2'b01, 0, 2'd0);
    tick(); push_exp("drain_c1", 1, 1, 0, 2'b00, 2'b00, 0, 2'd1);
    tick(); push_exp("drain_c2", 1, 1, 0, 2'b00, 2'b00, 0, 2'd1);
    tick(); push_exp("drain_c3", 1, 1, 0, 2'b00, 2'b00, 0, 2'd1);
    tick(); push_exp("halted", 1, 1, 0, 2'b00, 2'b00, 1, 2'd2);
    tick(); drain_req = 1'b0;
    push_exp("halted_release", 1, 1, 0, 2'b00, 2'b00, 1, 2'd2);
    tick(); push_exp("run_again", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);

    // flush honoured in DRAIN, then abort the drain
    tick(); set_id(1, 5'd3, 5'd1, 5'd0, 1, 0, 1, 1); drain_req = 1'b1;
    push_exp("drain2_req", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); id_none(); br_taken_ex = 1'b1;
    push_exp("drain_flush", 0, 1, 1, 2'b00, 2'b00, 0, 2'd1);
    tick(); br_taken_ex = 1'b0; drain_req = 1'b0;
    push_exp("drain_abort", 1, 1, 0, 2'b00, 2'b00, 0, 2'd1);
    tick(); push_exp("abort_run", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);

    // async reset between edges while draining
    tick(); drain_req = 1'b1;
    push_exp("drain3_req", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); push_exp("pre_reset", 1, 1, 0, 2'b00, 2'b00, 0, 2'd1);
    tick(); reset = 1'b0; drain_req = 1'b0;
    push_exp("async_reset", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); reset = 1'b1; set_id(1, 5'd12, 5'd3, 5'd3, 1, 1, 1, 0);
    push_exp("post_reset_run", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);
    tick(); id_none();
    push_exp("post_reset_clear", 0, 0, 0, 2'b00, 2'b00, 0, 2'd0);

    // let the monitor consume the last expectations
    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL queue_drain: %0d expectations left, required 0", exp_q.size());
    end
`ifdef HAZARD_CTRL_PERF_EN
    checks++;
    if (stall_cnt !== 32'(exp_stall_cnt)) begin
      fails++;
      $display("FAIL stall_cnt: got %0d required %0d", stall_cnt, exp_stall_cnt);
    end
    checks++;
    if (flush_cnt !== 32'(exp_flush_cnt)) begin
      fails++;
      $display("FAIL flush_cnt: got %0d required %0d", flush_cnt, exp_flush_cnt);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage core.
- Sits beside the ID/EX, EX/MEM and MEM/WB control registers.
- Keeps a 3-entry scoreboard of in-flight destination registers and raises load-use stalls and bubbles.
- Generates forwarding selects for the EX operands, squashes wrong-path instructions on a taken branch, and drains the pipeline on request (halt/debug).

Parameters:
REG_W, 5, register index width
ZERO_REG, 31, index of XZR; never a hazard or forward source

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
id_valid  in  1  instruction present in ID
id_rd  in  REG_W  ID destination
id_rn  in  REG_W  ID source A
id_rm  in  REG_W  ID source B
id_uses_rn  in  1  ID reads rn
id_uses_rm  in  1  ID reads rm
id_RegWrite  in  1  ID writes rd
id_MemRead  in  1  ID is a load
br_taken_ex  in  1  branch in EX resolved taken
drain_req  in  1  level request to empty the pipeline
stall  out  1  hold PC and IF/ID
bubble  out  1  force ID/EX control bus to zero
flush  out  1  squash IF/ID contents
fwd_a  out  2  EX operand A select: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_b  out  2  EX operand B select, same encoding
drain_done  out  1  pipeline empty and halted

Behaviour:
- Scoreboard entries EX, MEM, WB. Each holds: valid, rd, rn, rm, uses_rn, uses_rm, RegWrite, MemRead.
- Every cycle: WB <= MEM; MEM <= EX.
- EX <= ID fields when id_valid & !bubble & !flush; otherwise EX <= invalid.
- Reset (reset=0, async):
  - all entries invalid, FSM = RUN;
  - stall=0, bubble=0, flush=0, fwd_a=fwd_b=00, drain_done=0.
- Load-use hazard (combinational, same cycle):
  - Condition: EX.valid & EX.MemRead & EX.rd!=ZERO_REG & ((id_uses_rn & id_rn==EX.rd) | (id_uses_rm & id_rm==EX.rd)), with id_valid.
  - Response: stall=1, bubble=1 for exactly one cycle. The next cycle the load is in MEM and forwarding covers it.
- Forwarding for operand A (B identical using rm):
  - Select 01 if EX.uses_rn & MEM.valid & MEM.RegWrite & MEM.rd==EX.rn & MEM.rd!=ZERO_REG.
  - Else select 10 if the same condition holds on WB.
  - Else 00.
  - MEM has priority over WB (youngest producer wins).
- Taken branch:
  - br_taken_ex=1 gives flush=1 and bubble=1 that cycle. The ID instruction is dropped (EX <= invalid) and IF/ID is squashed.
  - The branch itself advances to MEM normally.
  - Flush overrides the load-use stall: stall=0 when flush=1.
- FSM states RUN, DRAIN, HALTED:
  - RUN: stall and bubble come from hazard detection only. drain_req=1 moves to DRAIN on the next edge.
  - DRAIN: stall=1 and bubble=1 every cycle. When EX, MEM and WB are all invalid, move to HALTED.
  - HALTED: stall=1, bubble=1, drain_done=1. drain_req=0 moves to RUN on the next edge, and drain_done drops in the same cycle.
  - drain_req deasserted while in DRAIN: return to RUN without passing through HALTED.
  - A flush during DRAIN is still honoured.
- Same-index producers in MEM and WB: MEM wins. A rd of ZERO_REG never stalls and never forwards.
- Reset asserted mid-operation: the scoreboard is cleared immediately. No in-flight state survives.

Optional Feature:
- Macro HAZARD_CTRL_PERF_EN.
- When defined, adds output ports stall_cnt[31:0] and flush_cnt[31:0]:
  - stall_cnt increments on every cycle with stall=1 & flush=0, including DRAIN/HALTED;
  - flush_cnt increments on every cycle with flush=1;
  - both wrap modulo 2^32 and are cleared by reset.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg:
  - fwd_sel_e enum (FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10);
  - sb_entry_t packed struct;
  - hc_state_e enum (RUN, DRAIN, HALTED);
  - ZERO_REG constant.
- Sub-module fwd_select: combinational, one source index plus MEM/WB entries in, fwd_sel_e out. It is instantiated twice (operands A and B).

Test Plan:
- Load-use: X3 loaded to EX (MemRead, rd=3); ID has rn=3 -> stall=1 and bubble=1 for exactly 1 cycle; next cycle fwd_a=10.
- ALU back-to-back: ADD X5 in MEM, EX.rn=5, and WB.rd=5 also -> fwd_a=01 (MEM priority); with only WB.rd=5 -> fwd_a=10.
- XZR: EX load with rd=31, ID rn=31 -> stall=0; MEM.rd=31 with EX.rn=31 -> fwd_a=00.
- Branch vs stall: br_taken_ex=1 in the same cycle as a load-use match -> flush=1, bubble=1, stall=0; EX entry invalid next cycle.
- Drain: 3 valid in-flight entries, drain_req=1 -> DRAIN for 3 cycles with stall=1, then drain_done=1; drain_req=0 -> RUN, drain_done=0 next cycle.
- Async reset mid-DRAIN: reset=0 between edges -> all outputs 0 immediately; after release the FSM is in RUN.
